// File: rtl/fp_pkg.sv
// ============================================================================
// Module      : fp_pkg
// Description : Shared constants, state encoding and format helpers for the
//               parametrised floating-point units.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_pkg;

    localparam logic [1:0] RND_RNE = 2'd0;
    localparam logic [1:0] RND_RTZ = 2'd1;
    localparam logic [1:0] RND_RUP = 2'd2;
    localparam logic [1:0] RND_RDN = 2'd3;

    // Bit positions inside the 4-bit flag word {invalid, overflow, underflow, inexact}
    localparam int FLG_INV = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_UNF = 1;
    localparam int FLG_INX = 0;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_UNPACK  = 4'd1,
        ST_SPECIAL = 4'd2,
        ST_NORM_A  = 4'd3,
        ST_NORM_B  = 4'd4,
        ST_MUL     = 4'd5,
        ST_EXTRACT = 4'd6,
        ST_NORM1   = 4'd7,
        ST_NORM2   = 4'd8,
        ST_ROUND   = 4'd9,
        ST_PACK    = 4'd10,
        ST_OUT     = 4'd11
    } fp_state_e;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int fp_word_w(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_round_inc.sv
// ============================================================================
// Module      : fp_round_inc
// Description : Rounding-increment decision from guard/round/sticky bits for
//               the four directed rounding modes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_round_inc
    import fp_pkg::*;
(
    input  logic [1:0] rnd_mode,
    input  logic       sign,
    input  logic       lsb,
    input  logic       g,
    input  logic       r,
    input  logic       s,
    output logic       increment,
    output logic       inexact
);

    logic w_any;

    assign w_any   = g | r | s;
    assign inexact = w_any;

    always_comb begin
        increment = 1'b0;
        case (rnd_mode)
            RND_RNE: increment = g & (r | s | lsb);
            RND_RTZ: increment = 1'b0;
            RND_RUP: increment = w_any & ~sign;
            RND_RDN: increment = w_any & sign;
            default: increment = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/fp_mul_param.sv
// ============================================================================
// Module      : fp_mul_param
// Description : Multi-cycle parametrised floating-point multiplier with
//               valid/ready handshakes, four rounding modes and flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_mul_param
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [fp_word_w(EXP_W, MAN_W)-1:0]   input_a,
    input  logic [fp_word_w(EXP_W, MAN_W)-1:0]   input_b,
    input  logic [1:0]                           rnd_mode,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [fp_word_w(EXP_W, MAN_W)-1:0]   output_z,
    output logic [3:0]                           out_flags
);

    localparam int c_w    = fp_word_w(EXP_W, MAN_W);
    localparam int c_bias = fp_bias(EXP_W);
    localparam int c_ew   = EXP_W + 2;
    localparam int c_mw   = MAN_W + 1;
    localparam int c_pw   = 2 * c_mw + 2;

    localparam logic signed [c_ew-1:0] c_emax = c_ew'(c_bias);
    localparam logic signed [c_ew-1:0] c_emin = c_ew'(1 - c_bias);
    localparam logic signed [c_ew-1:0] c_one  = c_ew'(1);

    localparam logic [c_w-2:0] c_inf_mag = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
    localparam logic [c_w-2:0] c_max_mag = {{(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    localparam logic [c_w-1:0] c_qnan    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    fp_state_e r_state;
    fp_state_e w_next;

    logic [c_w-1:0]         r_a;
    logic [c_w-1:0]         r_b;
    logic [1:0]             r_rnd;
    logic                   r_z_s;
    logic signed [c_ew-1:0] r_a_e;
    logic signed [c_ew-1:0] r_b_e;
    logic signed [c_ew-1:0] r_z_e;
    logic [c_mw-1:0]        r_a_m;
    logic [c_mw-1:0]        r_b_m;
    logic [c_mw-1:0]        r_z_m;
    logic [c_pw-1:0]        r_prod;
    logic                   r_g;
    logic                   r_r;
    logic                   r_s;
    logic                   r_tiny;
    logic                   r_inexact;
    logic [c_w-1:0]         r_z;
    logic [3:0]             r_flags;

    logic [EXP_W-1:0]       w_a_exp;
    logic [EXP_W-1:0]       w_b_exp;
    logic [MAN_W-1:0]       w_a_man;
    logic [MAN_W-1:0]       w_b_man;
    logic                   w_a_nan;
    logic                   w_b_nan;
    logic                   w_a_inf;
    logic                   w_b_inf;
    logic                   w_a_zero;
    logic                   w_b_zero;
    logic                   w_special;
    logic                   w_z_sign;
    logic [c_w-1:0]         w_spec_z;
    logic [3:0]             w_spec_f;
    logic [2*c_mw-1:0]      w_prod;
    logic [c_mw:0]          w_m_inc;
    logic                   w_inc;
    logic                   w_inx;
    logic                   w_ovf;
    logic signed [c_ew-1:0] w_e_biased;
    logic [c_w-1:0]         w_pack_z;
    logic [3:0]             w_pack_f;

    assign w_a_exp   = r_a[MAN_W +: EXP_W];
    assign w_b_exp   = r_b[MAN_W +: EXP_W];
    assign w_a_man   = r_a[MAN_W-1:0];
    assign w_b_man   = r_b[MAN_W-1:0];
    assign w_a_nan   = (&w_a_exp) && (|w_a_man);
    assign w_b_nan   = (&w_b_exp) && (|w_b_man);
    assign w_a_inf   = (&w_a_exp) && !(|w_a_man);
    assign w_b_inf   = (&w_b_exp) && !(|w_b_man);
    assign w_a_zero  = !(|w_a_exp) && !(|w_a_man);
    assign w_b_zero  = !(|w_b_exp) && !(|w_b_man);
    assign w_special = w_a_nan | w_b_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero;
    assign w_z_sign  = r_a[c_w-1] ^ r_b[c_w-1];

    assign w_prod     = {{c_mw{1'b0}}, r_a_m} * {{c_mw{1'b0}}, r_b_m};
    assign w_m_inc    = {1'b0, r_z_m} + {{c_mw{1'b0}}, 1'b1};
    assign w_ovf      = r_z_e > c_emax;
    assign w_e_biased = r_z_e + c_emax;

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_OUT);
    assign output_z  = r_z;
    assign out_flags = r_flags;

    fp_round_inc u_round_inc (
        .rnd_mode  (r_rnd),
        .sign      (r_z_s),
        .lsb       (r_z_m[0]),
        .g         (r_g),
        .r         (r_r),
        .s         (r_s),
        .increment (w_inc),
        .inexact   (w_inx)
    );

    always_comb begin
        w_spec_z = {w_z_sign, {(c_w-1){1'b0}}};
        w_spec_f = 4'b0000;
        if (w_a_nan || w_b_nan) begin
            w_spec_z = c_qnan;
        end else if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
            w_spec_z          = c_qnan;
            w_spec_f[FLG_INV] = 1'b1;
        end else if (w_a_inf || w_b_inf) begin
            w_spec_z = {w_z_sign, c_inf_mag};
        end
    end

    // Overflow saturates to infinity or max-finite depending on the rounding direction
    always_comb begin
        w_pack_z = {r_z_s, (r_z_m[MAN_W] ? w_e_biased[EXP_W-1:0] : {EXP_W{1'b0}}),
                    r_z_m[MAN_W-1:0]};
        if (w_ovf) begin
            case (r_rnd)
                RND_RNE: w_pack_z = {r_z_s, c_inf_mag};
                RND_RTZ: w_pack_z = {r_z_s, c_max_mag};
                RND_RUP: w_pack_z = r_z_s ? {1'b1, c_max_mag} : {1'b0, c_inf_mag};
                default: w_pack_z = r_z_s ? {1'b1, c_inf_mag} : {1'b0, c_max_mag};
            endcase
        end
        w_pack_f          = 4'b0000;
        w_pack_f[FLG_OVF] = w_ovf;
        w_pack_f[FLG_UNF] = r_tiny & r_inexact;
        w_pack_f[FLG_INX] = r_inexact | w_ovf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (in_valid) w_next = ST_UNPACK;
            ST_UNPACK:  w_next = ST_SPECIAL;
            ST_SPECIAL: w_next = w_special ? ST_OUT : ST_NORM_A;
            ST_NORM_A:  if (r_a_m[MAN_W]) w_next = ST_NORM_B;
            ST_NORM_B:  if (r_b_m[MAN_W]) w_next = ST_MUL;
            ST_MUL:     w_next = ST_EXTRACT;
            ST_EXTRACT: w_next = ST_NORM1;
            // The single left shift of a [1,2) product completes in the same cycle
            ST_NORM1:   if (r_z_m[MAN_W] || r_z_m[MAN_W-1]) w_next = ST_NORM2;
            ST_NORM2:   if (!(r_z_e < c_emin)) w_next = ST_ROUND;
            ST_ROUND:   w_next = ST_PACK;
            ST_PACK:    w_next = ST_OUT;
            ST_OUT:     if (out_ready) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_z     <= '0;
            r_flags <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a   <= input_a;
                        r_b   <= input_b;
                        r_rnd <= rnd_mode;
                    end
                end
                ST_UNPACK: begin
                    r_z_s <= w_z_sign;
                    r_a_m <= {|w_a_exp, w_a_man};
                    r_b_m <= {|w_b_exp, w_b_man};
                    r_a_e <= (|w_a_exp) ? $signed({2'b00, w_a_exp}) - c_emax : c_emin;
                    r_b_e <= (|w_b_exp) ? $signed({2'b00, w_b_exp}) - c_emax : c_emin;
                end
                ST_SPECIAL: begin
                    if (w_special) begin
                        r_z     <= w_spec_z;
                        r_flags <= w_spec_f;
                    end
                end
                ST_NORM_A: begin
                    if (!r_a_m[MAN_W]) begin
                        r_a_m <= r_a_m << 1;
                        r_a_e <= r_a_e - c_one;
                    end
                end
                ST_NORM_B: begin
                    if (!r_b_m[MAN_W]) begin
                        r_b_m <= r_b_m << 1;
                        r_b_e <= r_b_e - c_one;
                    end
                end
                ST_MUL: begin
                    r_prod <= {w_prod, 2'b00};
                    r_z_e  <= r_a_e + r_b_e + c_one;
                end
                ST_EXTRACT: begin
                    r_z_m <= r_prod[c_pw-1 -: c_mw];
                    r_g   <= r_prod[c_pw-1-c_mw];
                    r_r   <= r_prod[c_pw-2-c_mw];
                    r_s   <= |r_prod[c_pw-3-c_mw:0];
                end
                ST_NORM1: begin
                    if (!r_z_m[MAN_W]) begin
                        r_z_m <= {r_z_m[MAN_W-1:0], r_g};
                        r_g   <= r_r;
                        r_r   <= 1'b0;
                        r_z_e <= r_z_e - c_one;
                    end
                end
                ST_NORM2: begin
                    if (r_z_e < c_emin) begin
                        r_z_m <= r_z_m >> 1;
                        r_g   <= r_z_m[0];
                        r_r   <= r_g;
                        r_s   <= r_s | r_r;
                        r_z_e <= r_z_e + c_one;
                    end
                end
                ST_ROUND: begin
                    r_tiny    <= (r_z_e == c_emin) && !r_z_m[MAN_W];
                    r_inexact <= w_inx;
                    if (w_inc) begin
                        if (w_m_inc[c_mw]) begin
                            r_z_m <= {1'b1, {MAN_W{1'b0}}};
                            r_z_e <= r_z_e + c_one;
                        end else begin
                            r_z_m <= w_m_inc[c_mw-1:0];
                        end
                    end
                end
                ST_PACK: begin
                    r_z     <= w_pack_z;
                    r_flags <= w_pack_f;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
